// File: rtl/vram_arbiter.sv
// Shares a single-port frame-buffer RAM between scanout (top priority) and a pixel writer.
// Optional macro VRAM_ARB_HBLANK_EN also opens the write window during horizontal blanking.
module vram_arbiter #(
  parameter int AV_X   = 640,
  parameter int AV_Y   = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  output logic              o_in_vblank,
  output logic [15:0]       o_stall_cnt
);

  localparam logic [1:0] ST_SCAN   = 2'd0;
  localparam logic [1:0] ST_HBLANK = 2'd1;
  localparam logic [1:0] ST_VBLANK = 2'd2;

  localparam logic [9:0] LP_AV_X = 10'(AV_X);
  localparam logic [9:0] LP_AV_Y = 10'(AV_Y);

  logic              w_win;
  logic              w_hblank;
  logic              w_vblank;
  logic              w_frameStart;
  logic              w_writeWindow;
  logic              w_scanGrant;
  logic              w_writeGrant;
  logic [ADDR_W-1:0] w_scanAddr;
  logic [1:0]        w_nextState;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_scanAddr;
  logic [ADDR_W-1:0] r_memAddr;
  logic              r_memWe;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_pixValid1;
  logic              r_pixValid2;
  logic [15:0]       r_stallCnt;

  assign w_win        = (i_x < LP_AV_X) && (i_y < LP_AV_Y);
  assign w_hblank     = (i_y < LP_AV_Y) && (i_x >= LP_AV_X);
  assign w_vblank     = (i_y >= LP_AV_Y);
  assign w_frameStart = (i_x == 10'd0) && (i_y == 10'd0);

`ifdef VRAM_ARB_HBLANK_EN
  assign w_writeWindow = w_hblank || w_vblank;
`else
  assign w_writeWindow = w_vblank;
`endif

  // Write window is decoded from the live x/y so a writer is served on the first blank cycle.
  assign w_scanGrant  = w_win;
  assign w_writeGrant = !w_win && w_writeWindow && i_wr_req;
  assign o_wr_ack     = w_writeGrant && !i_reset;

  assign w_scanAddr = (w_win && w_frameStart) ? '0 : r_scanAddr;

  always_comb begin
    w_nextState = ST_SCAN;
    if (w_vblank)
      w_nextState = ST_VBLANK;
    else if (w_hblank)
      w_nextState = ST_HBLANK;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_SCAN;
      r_scanAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_scanGrant)
        r_scanAddr <= w_scanAddr + ADDR_W'(1);
    end
  end

  // Address and write data hold when idle so the RAM sees no spurious transitions.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_memAddr  <= '0;
      r_memWe    <= 1'b0;
      r_memWdata <= '0;
    end else if (w_scanGrant) begin
      r_memAddr <= w_scanAddr;
      r_memWe   <= 1'b0;
    end else if (w_writeGrant) begin
      r_memAddr  <= i_wr_addr;
      r_memWdata <= i_wr_data;
      r_memWe    <= 1'b1;
    end else begin
      r_memWe <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pixValid1 <= 1'b0;
      r_pixValid2 <= 1'b0;
    end else begin
      r_pixValid1 <= w_scanGrant;
      r_pixValid2 <= r_pixValid1;
    end
  end

  // Frame-start clear takes precedence over a stall in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_stallCnt <= '0;
    else if (w_frameStart)
      r_stallCnt <= '0;
    else if (i_wr_req && !w_writeGrant && (r_stallCnt != 16'hFFFF))
      r_stallCnt <= r_stallCnt + 16'd1;
  end

  assign o_mem_addr  = r_memAddr;
  assign o_mem_we    = r_memWe;
  assign o_mem_wdata = r_memWdata;
  assign o_pix_data  = i_mem_rdata;
  assign o_pix_valid = r_pixValid2;
  assign o_in_vblank = (r_state == ST_VBLANK);
  assign o_stall_cnt = r_stallCnt;

endmodule
